ex_muldiv: RTL and testbench

//  Iterative multiply/divide unit in the EX stage. It consumes the register operands that the
//  ID/EX pipeline register presents (r_data_1_out = rs, r_data_2_out = rt).

---
 rtl/ex_muldiv.sv | 127 ++++++++++++
 tb/tb_ex_muldiv.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit for the EX stage. It runs one shift-add or shift-subtract
// step per clock and holds the result in HI/LO until the next operation completes.
module ex_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // state | meaning
  // IDLE  | waiting for start; operands are latched on the start edge
  // RUN   | one multiply/divide iteration per clock, WIDTH clocks total
  // FIX   | signed fix-up; hi/lo are written on the edge leaving this state
  // DONE  | done pulse (and div_by_zero when flagged)
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt;
  logic                   is_div, neg_q, neg_r, div0;
  logic [WIDTH-1:0]       opb;
  logic [2*WIDTH-1:0]     acc;

  logic                   rs_neg, rt_neg, div_zero_req;
  logic [WIDTH-1:0]       rs_abs, rt_abs;
  logic [WIDTH:0]         mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0]     mul_step, div_step, prod_neg;
  logic [WIDTH-1:0]       res_hi, res_lo;

  // Unsigned ops (op[0]=1) never negate; abs(most-negative) wraps to itself and is used unsigned.
  assign rs_neg       = ~op[0] & rs_data[WIDTH-1];
  assign rt_neg       = ~op[0] & rt_data[WIDTH-1];
  assign rs_abs       = rs_neg ? -rs_data : rs_data;
  assign rt_abs       = rt_neg ? -rt_data : rt_data;
  assign div_zero_req = op[1] & (rt_data == '0);

  // acc = {partial product high, multiplier shifting out} or {remainder, dividend/quotient}
  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb : '0)};
  assign mul_step  = {mul_sum, acc[WIDTH-1:1]};
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opb};
  assign div_step  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};

  assign prod_neg = -acc;
  always_comb begin
    res_hi = acc[2*WIDTH-1:WIDTH];
    res_lo = acc[WIDTH-1:0];
    if (is_div) begin
      if (neg_r) res_hi = -acc[2*WIDTH-1:WIDTH];
      if (neg_q) res_lo = -acc[WIDTH-1:0];
    end else if (neg_q) begin
      res_hi = prod_neg[2*WIDTH-1:WIDTH];
      res_lo = prod_neg[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = div_zero_req ? DONE : RUN;
      RUN:     if (cnt == '0) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != IDLE);
    stall       = ((state == IDLE) && start) || (state == RUN) || (state == FIX);
    done        = (state == DONE);
    div_by_zero = (state == DONE) && div0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      opb    <= '0;
      acc    <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          is_div <= op[1];
          div0   <= div_zero_req;
          neg_q  <= rs_neg ^ rt_neg;
          neg_r  <= rs_neg;
          opb    <= rt_abs;
          acc    <= {{WIDTH{1'b0}}, rs_abs};
          cnt    <= CW'(WIDTH - 1);
        end
        RUN: begin
          acc <= is_div ? div_step : mul_step;
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          hi <= res_hi;
          lo <= res_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: expected HI/LO come from 64-bit integer arithmetic,
// a monitor pops the queue on every done pulse.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] rs_data = '0, rt_data = '0;
  logic        busy, stall, done, div_by_zero;
  logic [31:0] hi, lo;

  ex_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs_data(rs_data), .rt_data(rt_data),
    .busy(busy), .stall(stall), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          edge_n;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l, output logic dz);
    longint sa, sb, ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    dz = 1'b0;
    h  = m_hi;
    l  = m_lo;
    case (o)
      2'd0: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
      2'd1: begin p = ua * ub; h = p[63:32]; l = p[31:0]; end
      2'd2: if (b == 0) dz = 1'b1;
            else begin p = sa / sb; l = p[31:0]; p = sa % sb; h = p[31:0]; end
      default: if (b == 0) dz = 1'b1;
            else begin p = ua / ub; l = p[31:0]; p = ua % ub; h = p[31:0]; end
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_done actual=done expected=no_done (t=%0t)", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done_edge", 64'(cyc + 1), 64'(e.edge_n));
        chk("hi", {32'b0, hi}, {32'b0, e.hi});
        chk("lo", {32'b0, lo}, {32'b0, e.lo});
        chk("div_by_zero", {63'b0, div_by_zero}, {63'b0, e.dz});
        chk("stall_in_done", {63'b0, stall}, 64'd0);
        chk("busy_in_done", {63'b0, busy}, 64'd1);
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit extra_start);
    int   n = 0;
    int   s;
    exp_t e;
    logic [31:0] h, l;
    logic dz;
    @(negedge clk);
    while (busy && n < 100) begin @(negedge clk); n++; end
    if (busy) chk("idle_timeout", 64'd1, 64'd0);
    chk("hold_hi", {32'b0, hi}, {32'b0, m_hi});
    chk("hold_lo", {32'b0, lo}, {32'b0, m_lo});
    model(o, a, b, h, l, dz);
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    #1 chk("stall_on_start", {63'b0, stall}, 64'd1);
    @(posedge clk);
    #1;
    s = cyc;
    e.hi = h; e.lo = l; e.dz = dz; e.edge_n = s + (dz ? 1 : 34);
    exp_q.push_back(e);
    m_hi = h; m_lo = l;
    start = 1'b0; op = 2'($urandom); rs_data = $urandom; rt_data = $urandom;
    chk("stall_after_start", {63'b0, stall}, {63'b0, !dz});
    chk("busy_after_start", {63'b0, busy}, 64'd1);
    if (extra_start) begin
      repeat (4) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin
      chk("done_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    issue(o, a, b, 1'b0);
    drain();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h1;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_stall", {63'b0, stall}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_hi", {32'b0, hi}, 64'd0);
    chk("rst_lo", {32'b0, lo}, 64'd0);
    rst = 1'b0;

    do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(2'd0, 32'hFFFF_FFFD, 32'd7);
    do_op(2'd2, 32'hFFFF_FFF9, 32'd2);
    do_op(2'd3, 32'd100, 32'd7);
    do_op(2'd3, 32'h451, 32'h20);
    do_op(2'd3, 32'd5, 32'd0);
    @(negedge clk);
    chk("busy_after_div0", {63'b0, busy}, 64'd0);
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    drain();
    repeat (40) @(negedge clk);

    issue(2'd1, $urandom, $urandom, 1'b0);
    repeat (9) @(posedge clk);
    #3 rst = 1'b1;
    exp_q.delete();
    m_hi = '0; m_lo = '0;
    #1;
    chk("async_rst_busy", {63'b0, busy}, 64'd0);
    chk("async_rst_stall", {63'b0, stall}, 64'd0);
    chk("async_rst_hi", {32'b0, hi}, 64'd0);
    chk("async_rst_lo", {32'b0, lo}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_op(2'd1, 32'd6, 32'd7);

    for (int i = 0; i < 40; i++) begin
      logic [1:0] o;
      o = 2'($urandom);
      do_op(o, pick(), pick());
    end
    drain();
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
